ddr4_cmd_monitor: RTL and testbench
===================================

// Module: ddr4_cmd_monitor
// PURPOSE
//  Simulation-side DDR4 command-bus monitor for the DIMM models in hardware/sim/core.
//  - Sits in parallel with a DIMM model on the c0_ddr4_* pins.
//  - Decodes every command and tracks per-rank/per-bank row state.
//  - Flags protocol violations and keeps saturating command counters.
//  - Generalises the single-rank x16 wrapper: rank count, bank-group/bank widths and tRCD are parameters.
// PARAMETERS
//  RANKS      1   number of chip selects / ranks monitored
//  BG_WIDTH   1   bank-group address width (1 for x16, 2 for x4/x8)
//  BA_WIDTH   2   bank address width
//  ROW_WIDTH  17  row address bits taken from ADR on ACT
//  COL_WIDTH  10  column bits taken from ADR[COL_WIDTH-1:0] on RD/WR
//  TRCD_CK    16  ACT-to-RD/WR minimum, in CK cycles (>=1)
//  CNT_WIDTH  32  width of each command counter
// PORTS
//  c0_ddr4_ck_t     in   1                monitor clock; CK_t rising edge samples the bus
//  sys_reset        in   1                asynchronous reset, active-high
//  c0_ddr4_reset_n  in   1                DRAM reset pin
//  c0_ddr4_cke      in   RANKS            clock enable per rank
//  c0_ddr4_cs_n     in   RANKS            chip select per rank
//  c0_ddr4_act_n    in   1                activate command pin
//  c0_ddr4_adr      in   17               A16/RAS_n, A15/CAS_n, A14/WE_n, A13..A0
//  c0_ddr4_bg       in   BG_WIDTH         bank group
//  c0_ddr4_ba       in   BA_WIDTH         bank address
//  clr_cnt          in   1                synchronous clear of all counters
//  cmd_valid        out  1                one-cycle strobe: decoded command below is valid
//  cmd_type         out  4                ddr4_mon_pkg::cmd_e
//  cmd_rank         out  $clog2(RANKS)+1  rank of decoded command
//  cmd_bank         out  BG_WIDTH+BA_WIDTH {bg,ba}
//  cmd_row          out  ROW_WIDTH        row (ACT); otherwise the open row of the addressed bank
//  cmd_col          out  COL_WIDTH        column (RD/WR); 0 otherwise
//  cmd_ap           out  1                auto-precharge (A10) on RD/WR
//  open_mask        out  RANKS*2**(BG_WIDTH+BA_WIDTH)  1 = bank OPEN or ACTIVATING
//  err_valid        out  1                one-cycle strobe for a protocol violation
//  err_code         out  3                ddr4_mon_pkg::err_e
//  cnt_act, cnt_rd, cnt_wr, cnt_pre, cnt_ref  out  CNT_WIDTH each  saturating counters
// BEHAVIOUR
//  - Reset (sys_reset=1, async): all outputs 0, every bank IDLE, counters 0, timers 0.
//  - Sampling: a command is present on a CK_t rising edge when c0_ddr4_cke[r]=1 and cs_n[r]=0 for exactly one r.
//  - Decode:
//    - act_n=0 gives ACT with row=adr[ROW_WIDTH-1:0].
//    - Otherwise {A16,A15,A14} selects: 000 MRS, 001 REF, 010 PRE (A10=1: PREA), 011 RFU,
//      100 WR, 101 RD, 110 ZQC, 111 NOP.
//    - NOP and RFU give no cmd_valid; RFU raises ERR_RFU.
//  - Latency: cmd_* and err_* registered, valid 1 cycle after the sampling edge. Both may assert in the same cycle.
//  - Bank FSM (per rank/bank): IDLE -ACT-> ACTIVATING (timer=TRCD_CK-1) -timer==0-> OPEN -PRE/PREA/RD,WR with AP-> IDLE.
//    - TRCD_CK=1 goes IDLE->OPEN directly.
//    - AP close takes effect after the RD/WR is reported.
//  - Errors, one per cycle, priority in this order:
//    - ERR_MULTI_CS (1): more than one cs_n low; the command is dropped.
//    - ERR_IN_RESET (2): cs_n low while c0_ddr4_reset_n=0; the command is dropped.
//    - ERR_ACT_OPEN (3): ACT to a non-IDLE bank; row is overwritten, state restarts ACTIVATING.
//    - ERR_RW_IDLE (4): RD/WR to an IDLE bank; no state change.
//    - ERR_RW_TRCD (5): RD/WR to an ACTIVATING bank; AP is still honoured.
//    - ERR_REF_OPEN (6): REF while any bank of that rank is non-IDLE.
//    - ERR_RFU (7).
//  - PRE to an IDLE bank is legal (no error). PREA closes every bank of that rank.
//  - c0_ddr4_reset_n=0 forces all banks IDLE and timers 0 on the next edge; counters are kept.
//  - Counters: +1 per decoded command of that type, including erroneous ones.
//    - PREA counts into cnt_pre once.
//    - Saturate at all-ones.
//    - clr_cnt loads 0, or 1 if a matching command is reported in the same cycle.
//  - sys_reset mid-burst: immediate return to reset state; no partial strobes.
// STRUCTURE
//  - ddr4_mon_pkg holds:
//    - cmd_e: MRS=1, REF, PRE, PREA, ACT, WR, RD, ZQC
//    - err_e: codes above, 0 = none
//    - bank_state_e: IDLE, ACTIVATING, OPEN
//    - decode constants for {A16,A15,A14}
//  - One sub-module, ddr4_mon_bank: bank FSM, tRCD down-counter and row register.
//    Instantiated RANKS*2**(BG_WIDTH+BA_WIDTH) times via generate.
// TESTING
//  1. ACT rank0 bg0 ba1 row 0x1234, RD col 0x40 after 16 cycles
//     -> ACT strobe, then RD strobe with row 0x1234, col 0x40; err_valid never 1.
//  2. ACT then RD after 5 cycles (TRCD_CK=16)
//     -> err_code=5; then WR at cycle 20 with A10=1 -> no error, open_mask bit clears next cycle.
//  3. ACT bank 2 twice
//     -> second gives err_code=3, cnt_act=2. REF while bank 2 open -> err_code=6.
//  4. RANKS=2, both cs_n low with act_n=0 -> err_code=1, cnt_act unchanged, open_mask 0.
//  5. Force cnt_rd to all-ones - 1, issue 3 RDs -> saturates at all-ones.
//     clr_cnt coincident with RD -> cnt_rd=1.
//  6. Open 4 banks, PREA (A10=1) -> open_mask 0, cnt_pre +1.
//     Then sys_reset pulse mid-ACT sequence -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/ddr4_mon_pkg.sv
// DDR4 command monitor shared types.
// Command, error and bank-state encodings plus bus decode constants.
package ddr4_mon_pkg;

    typedef enum logic [3:0] {
        CMD_NONE = 4'd0,
        CMD_MRS  = 4'd1,
        CMD_REF  = 4'd2,
        CMD_PRE  = 4'd3,
        CMD_PREA = 4'd4,
        CMD_ACT  = 4'd5,
        CMD_WR   = 4'd6,
        CMD_RD   = 4'd7,
        CMD_ZQC  = 4'd8
    } cmd_e;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_MULTI_CS = 3'd1,
        ERR_IN_RESET = 3'd2,
        ERR_ACT_OPEN = 3'd3,
        ERR_RW_IDLE  = 3'd4,
        ERR_RW_TRCD  = 3'd5,
        ERR_REF_OPEN = 3'd6,
        ERR_RFU      = 3'd7
    } err_e;

    typedef enum logic [1:0] {
        BS_IDLE       = 2'd0,
        BS_ACTIVATING = 2'd1,
        BS_OPEN       = 2'd2
    } bank_state_e;

    // {A16/RAS_n, A15/CAS_n, A14/WE_n} when ACT_n is high
    localparam logic [2:0] DEC_MRS = 3'b000;
    localparam logic [2:0] DEC_REF = 3'b001;
    localparam logic [2:0] DEC_PRE = 3'b010;
    localparam logic [2:0] DEC_RFU = 3'b011;
    localparam logic [2:0] DEC_WR  = 3'b100;
    localparam logic [2:0] DEC_RD  = 3'b101;
    localparam logic [2:0] DEC_ZQC = 3'b110;
    localparam logic [2:0] DEC_NOP = 3'b111;

    function automatic logic is_rw(input cmd_e c);
        return (c == CMD_RD) || (c == CMD_WR);
    endfunction

endpackage

// File: rtl/ddr4_mon_bank.sv
// One DRAM bank tracker: IDLE/ACTIVATING/OPEN state,
// tRCD down-counter and the row latched by the last ACT.
module ddr4_mon_bank
    import ddr4_mon_pkg::*;
#(
    parameter int ROW_WIDTH = 17,
    parameter int TRCD_CK   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 force_idle,
    input  logic                 act,
    input  logic                 close,
    input  logic [ROW_WIDTH-1:0] act_row,
    output logic [1:0]           state,
    output logic [ROW_WIDTH-1:0] row
);

    localparam int TW = $clog2(TRCD_CK + 1);
    localparam logic [TW-1:0] TRCD_INIT = TW'(TRCD_CK - 1);

    bank_state_e          state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [ROW_WIDTH-1:0] row_q, row_d;

    assign state = state_q;
    assign row   = row_q;

    // State, timer and row registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BS_IDLE;
            timer_q <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            row_q   <= row_d;
        end
    end

    // Next state: DRAM reset beats ACT beats close beats the tRCD countdown.
    // The bank is usable once the countdown would reach zero, so a RD/WR
    // exactly TRCD_CK edges after ACT sees OPEN.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        row_d   = row_q;
        if (force_idle) begin
            state_d = BS_IDLE;
            timer_d = '0;
        end else if (act) begin
            row_d = act_row;
            if (TRCD_CK == 1) begin
                state_d = BS_OPEN;
                timer_d = '0;
            end else begin
                state_d = BS_ACTIVATING;
                timer_d = TRCD_INIT;
            end
        end else if (close) begin
            state_d = BS_IDLE;
            timer_d = '0;
        end else if (state_q == BS_ACTIVATING) begin
            if (timer_q <= TW'(1)) begin
                state_d = BS_OPEN;
                timer_d = '0;
            end else begin
                timer_d = timer_q - TW'(1);
            end
        end
    end

endmodule

// File: rtl/ddr4_cmd_monitor.sv
// DDR4 command-bus monitor: decodes commands, tracks per-bank
// row state, flags protocol violations and counts commands.
module ddr4_cmd_monitor
    import ddr4_mon_pkg::*;
#(
    parameter int RANKS     = 1,
    parameter int BG_WIDTH  = 1,
    parameter int BA_WIDTH  = 2,
    parameter int ROW_WIDTH = 17,
    parameter int COL_WIDTH = 10,
    parameter int TRCD_CK   = 16,
    parameter int CNT_WIDTH = 32
) (
    input  logic                                      c0_ddr4_ck_t,
    input  logic                                      sys_reset,
    input  logic                                      c0_ddr4_reset_n,
    input  logic [RANKS-1:0]                          c0_ddr4_cke,
    input  logic [RANKS-1:0]                          c0_ddr4_cs_n,
    input  logic                                      c0_ddr4_act_n,
    input  logic [16:0]                               c0_ddr4_adr,
    input  logic [BG_WIDTH-1:0]                       c0_ddr4_bg,
    input  logic [BA_WIDTH-1:0]                       c0_ddr4_ba,
    input  logic                                      clr_cnt,
    output logic                                      cmd_valid,
    output logic [3:0]                                cmd_type,
    output logic [$clog2(RANKS):0]                    cmd_rank,
    output logic [BG_WIDTH+BA_WIDTH-1:0]              cmd_bank,
    output logic [ROW_WIDTH-1:0]                      cmd_row,
    output logic [COL_WIDTH-1:0]                      cmd_col,
    output logic                                      cmd_ap,
    output logic [RANKS*2**(BG_WIDTH+BA_WIDTH)-1:0]   open_mask,
    output logic                                      err_valid,
    output logic [2:0]                                err_code,
    output logic [CNT_WIDTH-1:0]                      cnt_act,
    output logic [CNT_WIDTH-1:0]                      cnt_rd,
    output logic [CNT_WIDTH-1:0]                      cnt_wr,
    output logic [CNT_WIDTH-1:0]                      cnt_pre,
    output logic [CNT_WIDTH-1:0]                      cnt_ref
);

    localparam int BW    = BG_WIDTH + BA_WIDTH;
    localparam int NB    = 2 ** BW;
    localparam int NBANK = RANKS * NB;
    localparam int RW    = $clog2(RANKS) + 1;
    localparam int IW    = $clog2(NBANK);

    logic [RANKS-1:0]     cs_low, sel;
    logic [RW-1:0]        n_cs, n_sel, rank_i;
    logic [BW-1:0]        bank_a;
    logic [IW-1:0]        idx;
    logic [1:0]           st [NBANK];
    logic [ROW_WIDTH-1:0] rows [NBANK];
    logic [NBANK-1:0]     busy, bank_act, bank_close;
    logic [1:0]           cur_st;
    logic [2:0]           code;
    logic                 rfu, rank_busy, dram_rst;
    cmd_e                 raw, t_d;
    err_e                 e_d;
    logic                 v_d, act_go, close_one, close_all;
    logic [ROW_WIDTH-1:0] row_d;
    logic                 rw_d;

    assign cs_low   = ~c0_ddr4_cs_n;
    assign sel      = cs_low & c0_ddr4_cke;
    assign bank_a   = {c0_ddr4_bg, c0_ddr4_ba};
    assign idx      = IW'({rank_i, bank_a});
    assign cur_st   = st[idx];
    assign code     = c0_ddr4_adr[16:14];
    assign dram_rst = ~c0_ddr4_reset_n;

    // Count asserted chip selects and find the selected rank
    always_comb begin
        n_cs   = '0;
        n_sel  = '0;
        rank_i = '0;
        for (int r = 0; r < RANKS; r++) begin
            n_cs = n_cs + RW'(cs_low[r]);
            if (sel[r]) begin
                n_sel  = n_sel + RW'(1);
                rank_i = RW'(r);
            end
        end
    end

    // Any bank of the selected rank not idle
    always_comb begin
        rank_busy = 1'b0;
        for (int i = 0; i < NBANK; i++) begin
            if (RW'(i / NB) == rank_i) rank_busy = rank_busy | busy[i];
        end
    end

    // Raw command decode from ACT_n and {RAS_n,CAS_n,WE_n}
    always_comb begin
        raw = CMD_NONE;
        rfu = 1'b0;
        if (!c0_ddr4_act_n) begin
            raw = CMD_ACT;
        end else begin
            case (code)
                DEC_MRS: raw = CMD_MRS;
                DEC_REF: raw = CMD_REF;
                DEC_PRE: raw = c0_ddr4_adr[10] ? CMD_PREA : CMD_PRE;
                DEC_RFU: rfu = 1'b1;
                DEC_WR:  raw = CMD_WR;
                DEC_RD:  raw = CMD_RD;
                DEC_ZQC: raw = CMD_ZQC;
                DEC_NOP: raw = CMD_NONE;
                default: raw = CMD_NONE;
            endcase
        end
    end

    // Qualify the command, pick the highest-priority error, drive bank controls
    always_comb begin
        v_d       = 1'b0;
        t_d       = CMD_NONE;
        e_d       = ERR_NONE;
        act_go    = 1'b0;
        close_one = 1'b0;
        close_all = 1'b0;
        if (n_cs > RW'(1)) begin
            e_d = ERR_MULTI_CS;
        end else if (n_cs != '0 && dram_rst) begin
            e_d = ERR_IN_RESET;
        end else if (n_sel == RW'(1)) begin
            if (rfu) begin
                e_d = ERR_RFU;
            end else if (raw != CMD_NONE) begin
                v_d = 1'b1;
                t_d = raw;
                case (raw)
                    CMD_ACT: begin
                        act_go = 1'b1;
                        if (cur_st != BS_IDLE) e_d = ERR_ACT_OPEN;
                    end
                    CMD_RD, CMD_WR: begin
                        if (cur_st == BS_IDLE) begin
                            e_d = ERR_RW_IDLE;
                        end else begin
                            if (cur_st == BS_ACTIVATING) e_d = ERR_RW_TRCD;
                            close_one = c0_ddr4_adr[10];
                        end
                    end
                    CMD_PRE:  close_one = 1'b1;
                    CMD_PREA: close_all = 1'b1;
                    CMD_REF: begin
                        if (rank_busy) e_d = ERR_REF_OPEN;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Per-bank ACT and close strobes
    always_comb begin
        bank_act   = '0;
        bank_close = '0;
        for (int i = 0; i < NBANK; i++) begin
            bank_act[i]   = act_go && (idx == IW'(i));
            bank_close[i] = (close_one && (idx == IW'(i)))
                         || (close_all && (RW'(i / NB) == rank_i));
        end
    end

    for (genvar g = 0; g < NBANK; g++) begin : g_bank
        ddr4_mon_bank #(
            .ROW_WIDTH (ROW_WIDTH),
            .TRCD_CK   (TRCD_CK)
        ) u_bank (
            .clk        (c0_ddr4_ck_t),
            .rst        (sys_reset),
            .force_idle (dram_rst),
            .act        (bank_act[g]),
            .close      (bank_close[g]),
            .act_row    (c0_ddr4_adr[ROW_WIDTH-1:0]),
            .state      (st[g]),
            .row        (rows[g])
        );
        assign busy[g] = (st[g] != BS_IDLE);
    end

    assign open_mask = busy;
    assign rw_d      = v_d && is_rw(t_d);
    assign row_d     = (t_d == CMD_ACT) ? c0_ddr4_adr[ROW_WIDTH-1:0]
                                        : rows[idx];

    // Registered command and error report, one cycle after sampling
    always_ff @(posedge c0_ddr4_ck_t or posedge sys_reset) begin
        if (sys_reset) begin
            cmd_valid <= 1'b0;
            cmd_type  <= '0;
            cmd_rank  <= '0;
            cmd_bank  <= '0;
            cmd_row   <= '0;
            cmd_col   <= '0;
            cmd_ap    <= 1'b0;
            err_valid <= 1'b0;
            err_code  <= '0;
        end else begin
            cmd_valid <= v_d;
            cmd_type  <= v_d ? t_d : CMD_NONE;
            cmd_rank  <= v_d ? rank_i : '0;
            cmd_bank  <= v_d ? bank_a : '0;
            cmd_row   <= v_d ? row_d : '0;
            cmd_col   <= rw_d ? c0_ddr4_adr[COL_WIDTH-1:0] : '0;
            cmd_ap    <= rw_d & c0_ddr4_adr[10];
            err_valid <= (e_d != ERR_NONE);
            err_code  <= e_d;
        end
    end

    function automatic logic [CNT_WIDTH-1:0] cnt_nxt(
        input logic [CNT_WIDTH-1:0] c,
        input logic                 clr,
        input logic                 inc
    );
        if (clr) return inc ? CNT_WIDTH'(1) : '0;
        if (inc && (c != '1)) return c + CNT_WIDTH'(1);
        return c;
    endfunction

    // Saturating command counters, updated alongside the report
    always_ff @(posedge c0_ddr4_ck_t or posedge sys_reset) begin
        if (sys_reset) begin
            cnt_act <= '0;
            cnt_rd  <= '0;
            cnt_wr  <= '0;
            cnt_pre <= '0;
            cnt_ref <= '0;
        end else begin
            cnt_act <= cnt_nxt(cnt_act, clr_cnt, v_d && t_d == CMD_ACT);
            cnt_rd  <= cnt_nxt(cnt_rd,  clr_cnt, v_d && t_d == CMD_RD);
            cnt_wr  <= cnt_nxt(cnt_wr,  clr_cnt, v_d && t_d == CMD_WR);
            cnt_pre <= cnt_nxt(cnt_pre, clr_cnt,
                               v_d && (t_d == CMD_PRE || t_d == CMD_PREA));
            cnt_ref <= cnt_nxt(cnt_ref, clr_cnt, v_d && t_d == CMD_REF);
        end
    end

endmodule

// File: tb/tb_ddr4_cmd_monitor.sv
// Self-checking bench for ddr4_cmd_monitor: directed scenarios plus
// random bus traffic against a cycle-stamp bank model.
module tb_ddr4_cmd_monitor;

    localparam int RANKS = 2;
    localparam int CW    = 4;
    localparam int TRCD  = 16;
    localparam int CMAX  = (1 << CW) - 1;

    logic        clk = 1'b0;
    logic        sys_reset;
    logic        reset_n;
    logic [1:0]  cke, cs_n;
    logic        act_n;
    logic [16:0] adr;
    logic        bg;
    logic [1:0]  ba;
    logic        clr;

    logic        cmd_valid;
    logic [3:0]  cmd_type;
    logic [1:0]  cmd_rank;
    logic [2:0]  cmd_bank;
    logic [16:0] cmd_row;
    logic [9:0]  cmd_col;
    logic        cmd_ap;
    logic [15:0] open_mask;
    logic        err_valid;
    logic [2:0]  err_code;
    logic [3:0]  cnt_act, cnt_rd, cnt_wr, cnt_pre, cnt_ref;

    ddr4_cmd_monitor #(
        .RANKS(RANKS), .BG_WIDTH(1), .BA_WIDTH(2), .ROW_WIDTH(17),
        .COL_WIDTH(10), .TRCD_CK(TRCD), .CNT_WIDTH(CW)
    ) dut (
        .c0_ddr4_ck_t    (clk),
        .sys_reset       (sys_reset),
        .c0_ddr4_reset_n (reset_n),
        .c0_ddr4_cke     (cke),
        .c0_ddr4_cs_n    (cs_n),
        .c0_ddr4_act_n   (act_n),
        .c0_ddr4_adr     (adr),
        .c0_ddr4_bg      (bg),
        .c0_ddr4_ba      (ba),
        .clr_cnt         (clr),
        .cmd_valid       (cmd_valid),
        .cmd_type        (cmd_type),
        .cmd_rank        (cmd_rank),
        .cmd_bank        (cmd_bank),
        .cmd_row         (cmd_row),
        .cmd_col         (cmd_col),
        .cmd_ap          (cmd_ap),
        .open_mask       (open_mask),
        .err_valid       (err_valid),
        .err_code        (err_code),
        .cnt_act         (cnt_act),
        .cnt_rd          (cnt_rd),
        .cnt_wr          (cnt_wr),
        .cnt_pre         (cnt_pre),
        .cnt_ref         (cnt_ref)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model: a bank is active from its ACT until closed; it is usable
    // once TRCD cycles have passed since the ACT cycle stamp.
    bit          m_act  [16];
    int          m_acyc [16];
    logic [16:0] m_row  [16];
    int          m_cnt  [5];   // act, rd, wr, pre, ref

    bit          e_valid, e_ap, e_rowchk;
    int          e_type, e_rank, e_bank, e_col, e_err;
    logic [16:0] e_row;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 16; b++) begin
            m_act[b]  = 1'b0;
            m_acyc[b] = 0;
            m_row[b]  = '0;
        end
        for (int k = 0; k < 5; k++) m_cnt[k] = 0;
    endtask

    task automatic model_step();
        int ncs, nsel, r, b, cmd, ci;
        bit idle, activ;
        logic [2:0] code;
        ncs = 0; nsel = 0; r = 0; ci = -1;
        for (int i = 0; i < 2; i++) begin
            if (!cs_n[i]) ncs++;
            if (!cs_n[i] && cke[i]) begin nsel++; r = i; end
        end
        e_valid = 0; e_err = 0; e_type = 0; e_rowchk = 0;
        e_col = 0; e_ap = 0; e_rank = 0; e_bank = 0; e_row = '0;
        if (ncs > 1) e_err = 1;
        else if (ncs == 1 && !reset_n) e_err = 2;
        else if (nsel == 1) begin
            b = r * 8 + int'(bg) * 4 + int'(ba);
            code = adr[16:14];
            if (!act_n) cmd = 5;
            else case (code)
                3'd0: cmd = 1;
                3'd1: cmd = 2;
                3'd2: cmd = adr[10] ? 4 : 3;
                3'd3: cmd = -1;
                3'd4: cmd = 6;
                3'd5: cmd = 7;
                3'd6: cmd = 8;
                default: cmd = 0;
            endcase
            idle  = !m_act[b];
            activ = !idle && (cyc - m_acyc[b] < TRCD);
            if (cmd == -1) e_err = 7;
            else if (cmd != 0) begin
                e_valid  = 1; e_type = cmd; e_rank = r;
                e_bank   = int'(bg) * 4 + int'(ba);
                e_rowchk = (cmd == 5) || !idle;
                e_row    = (cmd == 5) ? adr : m_row[b];
                if (cmd == 6 || cmd == 7) begin
                    e_col = int'(adr[9:0]);
                    e_ap  = adr[10];
                end
                case (cmd)
                    5: begin
                        if (!idle) e_err = 3;
                        m_act[b] = 1; m_acyc[b] = cyc; m_row[b] = adr;
                        ci = 0;
                    end
                    6, 7: begin
                        if (idle) e_err = 4;
                        else begin
                            if (activ) e_err = 5;
                            if (adr[10]) m_act[b] = 0;
                        end
                        ci = (cmd == 7) ? 1 : 2;
                    end
                    3: begin m_act[b] = 0; ci = 3; end
                    4: begin
                        for (int k = 0; k < 8; k++) m_act[r * 8 + k] = 0;
                        ci = 3;
                    end
                    2: begin
                        for (int k = 0; k < 8; k++)
                            if (m_act[r * 8 + k]) e_err = 6;
                        ci = 4;
                    end
                    default: ;
                endcase
            end
        end
        for (int k = 0; k < 5; k++) begin
            if (clr) m_cnt[k] = (k == ci) ? 1 : 0;
            else if (k == ci) m_cnt[k] = (m_cnt[k] >= CMAX) ? CMAX : m_cnt[k] + 1;
        end
        if (!reset_n) for (int k = 0; k < 16; k++) m_act[k] = 0;
    endtask

    task automatic check();
        logic [15:0] m;
        for (int k = 0; k < 16; k++) m[k] = m_act[k];
        chk("cmd_valid", cmd_valid, e_valid);
        if (e_valid) begin
            chk("cmd_type", cmd_type, e_type);
            chk("cmd_rank", cmd_rank, e_rank);
            chk("cmd_bank", cmd_bank, e_bank);
            chk("cmd_col", cmd_col, e_col);
            chk("cmd_ap", cmd_ap, e_ap);
            if (e_rowchk) chk("cmd_row", cmd_row, e_row);
        end
        chk("err_valid", err_valid, e_err != 0);
        chk("err_code", err_code, e_err);
        chk("open_mask", open_mask, m);
        chk("cnt_act", cnt_act, m_cnt[0]);
        chk("cnt_rd", cnt_rd, m_cnt[1]);
        chk("cnt_wr", cnt_wr, m_cnt[2]);
        chk("cnt_pre", cnt_pre, m_cnt[3]);
        chk("cnt_ref", cnt_ref, m_cnt[4]);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check();
        cyc++;
    endtask

    task automatic bus(input logic [1:0] c, input logic an,
                       input logic [16:0] a, input logic g,
                       input logic [1:0] b);
        cs_n = c; act_n = an; adr = a; bg = g; ba = b;
    endtask

    task automatic nop();
        bus(2'b11, 1'b1, 17'h0, 1'b0, 2'd0);
    endtask

    function automatic logic [16:0] ca(input logic [2:0] c, input logic a10,
                                       input logic [9:0] col);
        return {c, 3'b000, a10, col};
    endfunction

    initial begin
        int p, k;
        logic [1:0] rc;
        sys_reset = 1'b1; reset_n = 1'b1; cke = 2'b11; clr = 1'b0;
        nop();
        model_reset();
        #12;
        chk("rst_valid", cmd_valid, 0);
        chk("rst_err", err_valid, 0);
        chk("rst_mask", open_mask, 0);
        chk("rst_cnt_act", cnt_act, 0);
        sys_reset = 1'b0;

        // Both chip selects low with ACT: dropped
        bus(2'b00, 1'b0, 17'h00abc, 1'b0, 2'd1); tick();
        chk("t4_err", err_code, 1);
        chk("t4_cnt_act", cnt_act, 0);
        chk("t4_mask", open_mask, 0);

        // ACT rank0 bank1 row 0x1234, RD 16 cycles later
        bus(2'b10, 1'b0, 17'h01234, 1'b0, 2'd1); tick();
        chk("t1_act_type", cmd_type, 5);
        repeat (15) begin nop(); tick(); end
        bus(2'b10, 1'b1, ca(3'b101, 1'b0, 10'h40), 1'b0, 2'd1); tick();
        chk("t1_rd_type", cmd_type, 7);
        chk("t1_rd_row", cmd_row, 17'h01234);
        chk("t1_rd_col", cmd_col, 10'h40);
        chk("t1_rd_err", err_valid, 0);

        // tRCD violation, then legal WR with auto-precharge
        bus(2'b10, 1'b0, 17'h00055, 1'b0, 2'd3); tick();
        repeat (4) begin nop(); tick(); end
        bus(2'b10, 1'b1, ca(3'b101, 1'b0, 10'h3), 1'b0, 2'd3); tick();
        chk("t2_trcd", err_code, 5);
        repeat (14) begin nop(); tick(); end
        chk("t2_open", open_mask[3], 1);
        bus(2'b10, 1'b1, ca(3'b100, 1'b1, 10'h7), 1'b0, 2'd3); tick();
        chk("t2_wr_err", err_valid, 0);
        chk("t2_closed", open_mask[3], 0);

        // Double ACT, then REF with open banks
        clr = 1'b1;
        bus(2'b10, 1'b0, 17'h00222, 1'b0, 2'd2); tick();
        clr = 1'b0;
        chk("t3_cnt1", cnt_act, 1);
        nop(); tick();
        bus(2'b10, 1'b0, 17'h00333, 1'b0, 2'd2); tick();
        chk("t3_err", err_code, 3);
        chk("t3_cnt2", cnt_act, 2);
        chk("t3_row", cmd_row, 17'h00333);
        bus(2'b10, 1'b1, ca(3'b001, 1'b0, 10'h0), 1'b0, 2'd0); tick();
        chk("t3_ref", err_code, 6);

        // PREA both ranks with four banks open on rank1
        bus(2'b10, 1'b1, ca(3'b010, 1'b1, 10'h0), 1'b0, 2'd0); tick();
        for (int i = 0; i < 4; i++) begin
            bus(2'b01, 1'b0, 17'(100 + i), 1'b0, 2'(i)); tick();
        end
        repeat (16) begin nop(); tick(); end
        chk("t6_mask4", open_mask, 16'h0f00);
        bus(2'b01, 1'b1, ca(3'b010, 1'b1, 10'h0), 1'b0, 2'd0); tick();
        chk("t6_mask0", open_mask, 0);
        chk("t6_type", cmd_type, 4);
        chk("t6_cnt_pre", cnt_pre, 2);

        // RD counter saturation and clear-with-increment
        clr = 1'b1;
        bus(2'b10, 1'b1, ca(3'b101, 1'b0, 10'h1), 1'b0, 2'd0); tick();
        clr = 1'b0;
        repeat (13) tick();
        chk("t5_near", cnt_rd, CMAX - 1);
        repeat (3) begin tick(); chk("t5_sat", cnt_rd, CMAX); end
        clr = 1'b1; tick(); clr = 1'b0;
        chk("t5_clr", cnt_rd, 1);

        // DRAM reset forces idle, counters kept
        bus(2'b10, 1'b0, 17'h00077, 1'b1, 2'd1); tick();
        reset_n = 1'b0; nop(); tick(); reset_n = 1'b1;
        chk("dr_mask", open_mask, 0);
        chk("dr_cnt", cnt_act, m_cnt[0]);

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            nop(); clr = 1'b0; cke = 2'b11; reset_n = 1'b1;
            p = $urandom_range(0, 99);
            if (p >= 45) begin
                k = $urandom_range(0, 19);
                rc = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
                if (k == 0) rc = 2'b00;
                adr = 17'($urandom);
                act_n = 1'b1;
                k = $urandom_range(0, 19);
                if (k < 6) act_n = 1'b0;
                else if (k < 10) adr[16:14] = 3'b101;
                else if (k < 13) adr[16:14] = 3'b100;
                else if (k < 16) adr[16:14] = 3'b010;
                else if (k == 16) adr[16:14] = 3'b001;
                else if (k == 17) adr[16:14] = ($urandom_range(0, 1) != 0) ? 3'b000 : 3'b110;
                else if (k == 18) adr[16:14] = 3'b011;
                else adr[16:14] = 3'b111;
                cs_n = rc;
                bg = 1'($urandom);
                ba = 2'($urandom);
                if ($urandom_range(0, 19) == 0) cke = 2'($urandom);
                if ($urandom_range(0, 49) == 0) reset_n = 1'b0;
                if ($urandom_range(0, 32) == 0) clr = 1'b1;
            end
            tick();
        end
        nop(); clr = 1'b0; cke = 2'b11; reset_n = 1'b1;

        // Asynchronous reset in the middle of an ACT sequence
        bus(2'b10, 1'b0, 17'h00abc, 1'b0, 2'd0); tick();
        chk("sr_pre_valid", cmd_valid, 1);
        bus(2'b10, 1'b0, 17'h00abd, 1'b1, 2'd2);
        #2 sys_reset = 1'b1;
        #1;
        chk("sr_valid", cmd_valid, 0);
        chk("sr_type", cmd_type, 0);
        chk("sr_mask", open_mask, 0);
        chk("sr_cnt_act", cnt_act, 0);
        chk("sr_err", err_valid, 0);
        model_reset();
        nop();
        @(posedge clk); #1;
        chk("sr_hold", cmd_valid, 0);
        #2 sys_reset = 1'b0;
        nop(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
